// File: rtl/hc595_rx.sv
// hc595_rx: receives a 74HC595-style serial stream (shcp/ds/stcp/oe) that is
// asynchronous to clk and presents the latched parallel frame with
// frame-length error tracking.
module hc595_rx #(
  parameter int unsigned FRAME_BITS = 14,
  parameter int unsigned ERR_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shcp,
  input  logic                  ds,
  input  logic                  stcp,
  input  logic                  oe,
  output logic [FRAME_BITS-1:0] q,
  output logic                  q_en,
  output logic                  frame_valid,
  output logic                  len_err,
  output logic [ERR_W-1:0]      err_cnt,
  output logic [4:0]            bit_cnt
);

  localparam int unsigned NPIN    = 4;
  localparam int unsigned P_SHCP  = 0;
  localparam int unsigned P_DS    = 1;
  localparam int unsigned P_STCP  = 2;
  localparam int unsigned P_OE    = 3;
  localparam int unsigned CNT_W   = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_BITS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_OVER  = 2'd2
  } state_e;

  logic [NPIN-1:0]       pins;
  logic [NPIN-1:0]       sync1_q;
  logic [NPIN-1:0]       sync2_q;
  logic [NPIN-1:0]       dly_q;
  logic [1:0]            prime_q;
  logic                  arm_shcp_q;
  logic                  arm_stcp_q;
  logic                  sh_edge;
  logic                  st_edge;
  logic                  ds_bit;

  state_e                state_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [FRAME_BITS-1:0] q_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [ERR_W-1:0]      err_cnt_q;
  logic                  frame_valid_q;
  logic                  len_err_q;
  logic                  q_en_q;

  assign pins = {oe, stcp, ds, shcp};

  // Two-flop synchronizers followed by one delay stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      dly_q   <= '0;
    end else begin
      sync1_q <= pins;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  // Edge arming: after reset the pipeline must fill and each clock pin must be
  // seen low before its rising edges count, so a pin high at release is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      prime_q    <= 2'd0;
      arm_shcp_q <= 1'b0;
      arm_stcp_q <= 1'b0;
    end else begin
      if (prime_q != 2'd3) begin
        prime_q <= prime_q + 2'd1;
      end
      if (prime_q == 2'd3 && !sync2_q[P_SHCP]) begin
        arm_shcp_q <= 1'b1;
      end
      if (prime_q == 2'd3 && !sync2_q[P_STCP]) begin
        arm_stcp_q <= 1'b1;
      end
    end
  end

  assign sh_edge = sync2_q[P_SHCP] & ~dly_q[P_SHCP] & arm_shcp_q;
  assign st_edge = sync2_q[P_STCP] & ~dly_q[P_STCP] & arm_stcp_q;
  // ds taken from its delay stage: the value held one cycle before shcp rose.
  assign ds_bit  = dly_q[P_DS];

  // Frame FSM: shift on shcp edges, latch on stcp edges, track length errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      shift_q       <= '0;
      q_q           <= '0;
      bit_cnt_q     <= '0;
      err_cnt_q     <= '0;
      frame_valid_q <= 1'b0;
      len_err_q     <= 1'b0;
      q_en_q        <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      len_err_q     <= 1'b0;
      q_en_q        <= ~dly_q[P_OE];

      if (sh_edge) begin
        shift_q <= {shift_q[FRAME_BITS-2:0], ds_bit};
      end

      if (st_edge) begin
        // Latch takes pre-shift contents even when shcp fires in the same cycle.
        q_q           <= shift_q;
        frame_valid_q <= 1'b1;
        if (state_q != ST_SHIFT || bit_cnt_q != FRAME_CNT) begin
          len_err_q <= 1'b1;
          if (err_cnt_q != '1) begin
            err_cnt_q <= err_cnt_q + ERR_W'(1);
          end
        end
        if (sh_edge) begin
          state_q   <= ST_SHIFT;
          bit_cnt_q <= CNT_W'(1);
        end else begin
          state_q   <= ST_IDLE;
          bit_cnt_q <= '0;
        end
      end else if (sh_edge) begin
        if (bit_cnt_q != CNT_MAX) begin
          bit_cnt_q <= bit_cnt_q + CNT_W'(1);
        end
        case (state_q)
          ST_IDLE:  state_q <= ST_SHIFT;
          ST_SHIFT: if (bit_cnt_q == FRAME_CNT) state_q <= ST_OVER;
          ST_OVER:  state_q <= ST_OVER;
          default:  state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign q           = q_q;
  assign q_en        = q_en_q;
  assign frame_valid = frame_valid_q;
  assign len_err     = len_err_q;
  assign err_cnt     = err_cnt_q;
  assign bit_cnt     = bit_cnt_q;

endmodule
